// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry integer register file, x0 hardwired to zero, with arbitrated debug port
// Optional write-through forwarding on the read ports: REGFILE_BYPASS_EN
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_we_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          rs1_re_i,
  input  logic [AW-1:0] rs1_addr_i,
  output logic [DW-1:0] rs1_data_o,
  input  logic          rs2_re_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic [DW-1:0] rs2_data_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o
);

  localparam int NREG = 1 << AW;

  // x0 is never stored; entry 0 does not exist
  logic [DW-1:0] regs [NREG-1:1];

  logic pipe_wr;
  logic dbg_wr;
  logic dbg_rd;

  assign pipe_wr   = rd_we_i && (rd_addr_i != '0);
  assign dbg_gnt_o = dbg_req_i && !pipe_wr;
  assign dbg_wr    = dbg_gnt_o && dbg_we_i && (dbg_addr_i != '0);
  assign dbg_rd    = dbg_gnt_o && !dbg_we_i;

  // Pipeline writes and debug writes never share an edge: a pipeline write blocks the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (pipe_wr) begin
      regs[rd_addr_i] <= rd_data_i;
    end else if (dbg_wr) begin
      regs[dbg_addr_i] <= dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      dbg_rvalid_o <= dbg_rd;
      if (dbg_rd) begin
        dbg_rdata_o <= (dbg_addr_i == '0) ? '0 : regs[dbg_addr_i];
      end
    end
  end

  function automatic logic [DW-1:0] read_port(input logic re, input logic [AW-1:0] addr);
    logic [DW-1:0] val;
    val = '0;
    if (re && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (pipe_wr && (rd_addr_i == addr)) begin
        val = rd_data_i;
      end else begin
        val = regs[addr];
      end
`else
      val = regs[addr];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_re_i, rs1_addr_i);
    rs2_data_o = read_port(rs2_re_i, rs2_addr_i);
  end

endmodule
